// File: rtl/vec_alu_exec_if.sv
// Operation request / result handshake bundle for vec_alu_exec.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; the sender holds its payload stable while
// valid is high and ready is low.
interface vec_alu_exec_if #(
    parameter int LANES = 4,
    parameter int LW    = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            alu_op;
    logic [LANES*LW-1:0]   op_a;
    logic [LANES*LW-1:0]   op_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [LANES*LW-1:0]   result;
    logic [3:0]            flags;
    logic                  div_zero;

    // Upstream decoder / downstream consumer side
    modport master (
        output in_valid, alu_op, op_a, op_b, res_ready,
        input  in_ready, res_valid, result, flags, div_zero
    );

    // Execution unit side
    modport slave (
        input  in_valid, alu_op, op_a, op_b, res_ready,
        output in_ready, res_valid, result, flags, div_zero
    );
endinterface

// File: rtl/vec_alu_exec.sv
// Lane-parallel unsigned vector ALU. Pass/add/sub/mul complete on the accept
// edge; divide runs one restoring step per cycle for LW cycles, all lanes in
// parallel. Result is held in DONE until the consumer takes it, and a new
// operation may be accepted on the same edge the old result is consumed.
module vec_alu_exec #(
    parameter int LANES = 4,
    parameter int LW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    vec_alu_exec_if.slave       bus,
    output logic [1:0]          state_dbg
);
    localparam int CW = $clog2(LW + 1);

    localparam logic [2:0] OP_PASS = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                        ready_int;
    logic                        accept;
    logic                        is_div_in;
    logic                        last_step;
    logic [CW-1:0]               cnt;

    logic [LANES-1:0][LW-1:0]    a_in, b_in, alu_res;
    logic [3:0]                  flags_in;
    logic [LW:0]                 sum0;
    logic                        b_any_zero;

    logic [LANES-1:0][LW-1:0]    div_q, div_r, div_d;
    logic [LANES-1:0][LW-1:0]    step_q, step_r;
    logic [LW:0]                 r_sh;
    logic                        dz_pend;

    logic [LANES-1:0][LW-1:0]    result_q;
    logic [3:0]                  flags_q;
    logic                        dz_q;

    assign a_in      = bus.op_a;
    assign b_in      = bus.op_b;
    assign is_div_in = (bus.alu_op == OP_DIV);
    assign accept    = bus.in_valid && ready_int;
    assign last_step = (cnt == CW'(LW - 1));

    assign bus.in_ready  = ready_int;
    assign bus.res_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.div_zero  = dz_q;
    assign state_dbg     = state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and input-side ready
    always_comb begin
        state_nxt = state;
        ready_int = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = is_div_in ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready_int = bus.res_ready;
                if (bus.res_ready) begin
                    if (bus.in_valid) begin
                        state_nxt = is_div_in ? BUSY : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            ready_int = 1'b0;
        end
    end

    // Single-cycle lane results for the non-divide ops
    always_comb begin
        alu_res    = '0;
        b_any_zero = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            case (bus.alu_op)
                OP_PASS: alu_res[i] = a_in[i];
                OP_ADD:  alu_res[i] = a_in[i] + b_in[i];
                OP_SUB:  alu_res[i] = a_in[i] - b_in[i];
                OP_MUL:  alu_res[i] = a_in[i] * b_in[i];
                default: alu_res[i] = '0;
            endcase
            if (b_in[i] == '0) begin
                b_any_zero = 1'b1;
            end
        end
    end

    // Lane-0 flags {N,Z,C,V}; carry/overflow only meaningful for add/sub
    always_comb begin
        sum0     = {1'b0, a_in[0]} + {1'b0, b_in[0]};
        flags_in = 4'b0000;
        case (bus.alu_op)
            OP_ADD: flags_in = {alu_res[0][LW-1], alu_res[0] == '0, sum0[LW],
                                (a_in[0][LW-1] == b_in[0][LW-1]) &&
                                (alu_res[0][LW-1] != a_in[0][LW-1])};
            OP_SUB: flags_in = {alu_res[0][LW-1], alu_res[0] == '0,
                                a_in[0] < b_in[0],
                                (a_in[0][LW-1] != b_in[0][LW-1]) &&
                                (alu_res[0][LW-1] != a_in[0][LW-1])};
            OP_PASS, OP_MUL:
                    flags_in = {alu_res[0][LW-1], alu_res[0] == '0, 2'b00};
            default: flags_in = 4'b0000;
        endcase
    end

    // One restoring-division step per lane; a zero divisor always
    // "subtracts", which naturally yields an all-ones quotient
    always_comb begin
        r_sh   = '0;
        step_q = '0;
        step_r = '0;
        for (int i = 0; i < LANES; i++) begin
            r_sh = {div_r[i], div_q[i][LW-1]};
            if (r_sh >= {1'b0, div_d[i]}) begin
                step_r[i] = LW'(r_sh - {1'b0, div_d[i]});
                step_q[i] = {div_q[i][LW-2:0], 1'b1};
            end else begin
                step_r[i] = r_sh[LW-1:0];
                step_q[i] = {div_q[i][LW-2:0], 1'b0};
            end
        end
    end

    // Operand latching, divide iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            dz_q     <= 1'b0;
            cnt      <= '0;
            div_q    <= '0;
            div_r    <= '0;
            div_d    <= '0;
            dz_pend  <= 1'b0;
        end else if (accept) begin
            if (is_div_in) begin
                div_q   <= a_in;
                div_r   <= '0;
                div_d   <= b_in;
                cnt     <= '0;
                dz_pend <= b_any_zero;
            end else begin
                result_q <= alu_res;
                flags_q  <= flags_in;
                dz_q     <= 1'b0;
            end
        end else if (state == BUSY) begin
            div_q <= step_q;
            div_r <= step_r;
            cnt   <= cnt + CW'(1);
            if (last_step) begin
                result_q <= step_q;
                flags_q  <= {step_q[0][LW-1], step_q[0] == '0, 2'b00};
                dz_q     <= dz_pend;
            end
        end
    end
endmodule
